// File: rtl/delta_controller_output_storer.sv
// delta_controller_output_storer: drains output-buffer tiles into Output SRAM and
// copies the packed Output SRAM image out to DRAM as 32-bit halves.
module delta_controller_output_storer #(
   parameter int MAX_OUTPUT_CHANNEL = 64,
   parameter int MAX_FEATURE_SIZE   = 64,
   parameter int OUTPUT_CHANNEL     = 4,
   parameter int OUTPUT_HEIGHT      = 8,
   localparam int OCW = $clog2(MAX_OUTPUT_CHANNEL) + 1,
   localparam int RCW = $clog2(MAX_FEATURE_SIZE) + 1,
   localparam int CHW = $clog2(OUTPUT_CHANNEL),
   localparam int RW  = $clog2(OUTPUT_HEIGHT)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start_buffer_store,
   input  logic           start_DRAM_store,
   input  logic [OCW-1:0] OC_Num,
   input  logic [RCW-1:0] RC_Size,
   input  logic [31:0]    output_start_address,
   output logic           OB_r_en,
   output logic [CHW-1:0] OB_r_ch,
   output logic [RW-1:0]  OB_r_row,
   input  logic [63:0]    OB_r_data,
   output logic           Output_SRAM_w_en,
   output logic           Output_SRAM_r_en,
   output logic [31:0]    Output_SRAM_w_addr,
   output logic [31:0]    Output_SRAM_r_addr,
   output logic [63:0]    Output_SRAM_w_d,
   input  logic [63:0]    Output_SRAM_r_d,
   input  logic           Output_SRAM_d_ready,
   input  logic           Output_SRAM_w_done,
   output logic           DRAM_Write,
   output logic [31:0]    DRAM_Address,
   output logic [31:0]    DRAM_WriteData,
   input  logic           DRAM_WriteDone,
   output logic           busy,
   output logic           finished
);
   typedef enum logic [3:0] {
      IDLE, B_RD, B_CAP, B_WR, B_IDX, B_TILE, B_FIN,
      D_CHECK, D_RD, D_LO, D_HI, D_IDX, D_FIN
   } state_t;

   state_t         state_q, state_d;
   logic [CHW-1:0] ch_q, ch_d;
   logic [RW-1:0]  r_q, r_d;
   logic [31:0]    tile_ch_q, tile_ch_d, tile_row_q, tile_row_d, tile_col_q, tile_col_d;
   logic [31:0]    idx_q, idx_d;
   logic [63:0]    wd_q, wd_d, rd_q, rd_d;
   logic [31:0]    oc, rc, plane, words, col_n, row_n, w_addr, d_addr;
   logic           r_last, last_word;

   assign oc        = 32'(OC_Num) & ~32'd3;
   assign rc        = 32'(RC_Size) & ~32'd7;
   assign plane     = rc * rc;
   assign words     = (oc * plane) >> 3;
   assign col_n     = tile_col_q + 32'd8;
   assign row_n     = tile_row_q + 32'd8;
   assign r_last    = r_q == RW'(OUTPUT_HEIGHT - 1);
   assign last_word = r_last && ch_q == CHW'(OUTPUT_CHANNEL - 1);
   assign w_addr    = (tile_ch_q + 32'(ch_q)) * plane + (tile_row_q + 32'(r_q)) * rc + tile_col_q;
   assign d_addr    = output_start_address + (idx_q << 3);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ch_q       <= '0;
         r_q        <= '0;
         tile_ch_q  <= '0;
         tile_row_q <= '0;
         tile_col_q <= '0;
         idx_q      <= '0;
         wd_q       <= '0;
         rd_q       <= '0;
      end else begin
         state_q    <= state_d;
         ch_q       <= ch_d;
         r_q        <= r_d;
         tile_ch_q  <= tile_ch_d;
         tile_row_q <= tile_row_d;
         tile_col_q <= tile_col_d;
         idx_q      <= idx_d;
         wd_q       <= wd_d;
         rd_q       <= rd_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      r_d        = r_q;
      tile_ch_d  = tile_ch_q;
      tile_row_d = tile_row_q;
      tile_col_d = tile_col_q;
      idx_d      = idx_q;
      wd_d       = wd_q;
      rd_d       = rd_q;
      case (state_q)
         IDLE:    state_d = start_buffer_store ? B_RD : start_DRAM_store ? D_CHECK : IDLE;
         B_RD:    state_d = B_CAP;
         B_CAP: begin
            wd_d    = OB_r_data;
            state_d = B_WR;
         end
         B_WR:    state_d = Output_SRAM_w_done ? B_IDX : B_WR;
         B_IDX: begin
            r_d     = r_last ? '0 : r_q + RW'(1);
            ch_d    = last_word ? '0 : r_last ? ch_q + CHW'(1) : ch_q;
            state_d = last_word ? B_TILE : B_RD;
         end
         // raster order over the image: columns, then rows, then channel groups
         B_TILE: begin
            tile_col_d = col_n >= rc ? '0 : col_n;
            tile_row_d = col_n >= rc ? (row_n >= rc ? '0 : row_n) : tile_row_q;
            tile_ch_d  = (col_n >= rc && row_n >= rc) ? tile_ch_q + 32'(OUTPUT_CHANNEL) : tile_ch_q;
            state_d    = B_FIN;
         end
         B_FIN:   state_d = IDLE;
         D_CHECK: state_d = idx_q == words ? D_FIN : D_RD;
         D_RD: begin
            rd_d    = Output_SRAM_d_ready ? Output_SRAM_r_d : rd_q;
            state_d = Output_SRAM_d_ready ? D_LO : D_RD;
         end
         D_LO:    state_d = DRAM_WriteDone ? D_HI : D_LO;
         D_HI:    state_d = DRAM_WriteDone ? D_IDX : D_HI;
         D_IDX: begin
            idx_d   = idx_q + 32'd1;
            state_d = D_CHECK;
         end
         D_FIN: begin
            idx_d      = '0;
            tile_ch_d  = '0;
            tile_row_d = '0;
            tile_col_d = '0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // addresses are zeroed outside their states so everything reads 0 while in reset
   assign OB_r_en            = state_q == B_RD;
   assign OB_r_ch            = OB_r_en ? ch_q : '0;
   assign OB_r_row           = OB_r_en ? r_q : '0;
   assign Output_SRAM_w_en   = state_q == B_WR;
   assign Output_SRAM_w_addr = Output_SRAM_w_en ? w_addr : '0;
   assign Output_SRAM_w_d    = wd_q;
   assign Output_SRAM_r_en   = state_q == D_RD;
   assign Output_SRAM_r_addr = Output_SRAM_r_en ? idx_q << 3 : '0;
   assign DRAM_Write         = state_q == D_LO || state_q == D_HI;
   assign DRAM_Address       = state_q == D_LO ? d_addr : state_q == D_HI ? d_addr + 32'd4 : '0;
   assign DRAM_WriteData     = state_q == D_LO ? rd_q[31:0] : state_q == D_HI ? rd_q[63:32] : '0;
   assign busy               = state_q != IDLE;
   assign finished           = state_q == B_FIN || state_q == D_FIN;
endmodule

// File: tb/tb_delta_controller_output_storer.sv
// tb_delta_controller_output_storer: random-latency memory responders feed a scoreboard
// whose expectations come from an image-level reference model.
module tb_delta_controller_output_storer;
   logic        clock, reset, start_buffer_store, start_DRAM_store;
   logic [6:0]  OC_Num, RC_Size;
   logic [31:0] output_start_address;
   logic        OB_r_en;
   logic [1:0]  OB_r_ch;
   logic [2:0]  OB_r_row;
   logic [63:0] OB_r_data;
   logic        Output_SRAM_w_en, Output_SRAM_r_en;
   logic [31:0] Output_SRAM_w_addr, Output_SRAM_r_addr;
   logic [63:0] Output_SRAM_w_d, Output_SRAM_r_d;
   logic        Output_SRAM_d_ready, Output_SRAM_w_done;
   logic        DRAM_Write;
   logic [31:0] DRAM_Address, DRAM_WriteData;
   logic        DRAM_WriteDone, busy, finished;

   delta_controller_output_storer dut (
      .clock(clock), .reset(reset),
      .start_buffer_store(start_buffer_store), .start_DRAM_store(start_DRAM_store),
      .OC_Num(OC_Num), .RC_Size(RC_Size), .output_start_address(output_start_address),
      .OB_r_en(OB_r_en), .OB_r_ch(OB_r_ch), .OB_r_row(OB_r_row), .OB_r_data(OB_r_data),
      .Output_SRAM_w_en(Output_SRAM_w_en), .Output_SRAM_r_en(Output_SRAM_r_en),
      .Output_SRAM_w_addr(Output_SRAM_w_addr), .Output_SRAM_r_addr(Output_SRAM_r_addr),
      .Output_SRAM_w_d(Output_SRAM_w_d), .Output_SRAM_r_d(Output_SRAM_r_d),
      .Output_SRAM_d_ready(Output_SRAM_d_ready), .Output_SRAM_w_done(Output_SRAM_w_done),
      .DRAM_Write(DRAM_Write), .DRAM_Address(DRAM_Address), .DRAM_WriteData(DRAM_WriteData),
      .DRAM_WriteDone(DRAM_WriteDone), .busy(busy), .finished(finished)
   );

   typedef struct {
      logic [31:0] a;
      logic [63:0] d;
   } xfer_t;

   xfer_t       wq[$], dq[$];
   logic [31:0] rq[$], w_log[$], d_log[$];
   logic [63:0] sram [logic [31:0]];
   logic [63:0] ref_mem [logic [31:0]];
   logic [63:0] tile [4][8];
   logic [31:0] bases [5] = '{32'd0, 32'd8, 32'd128, 32'd136, 32'd1024};
   logic [31:0] mtc, mtr, mcol;
   int          total, bad, fin_cnt, exp_fin, dram_delay;
   int          w_wait, r_wait, d_wait;
   bit          w_pend, r_pend, d_pend, ob_prev;
   logic [31:0] w_a, r_a, d_a;
   logic [63:0] w_dd;
   logic [31:0] d_dd;
   logic [1:0]  ob_pc;
   logic [2:0]  ob_pr;

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   function automatic void chk(string n, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", n, act, exp);
      end
   endfunction

   function automatic void miss(string n, logic [31:0] a);
      total++;
      bad++;
      $display("FAIL %s got_addr=%0h expected=no_transfer", n, a);
   endfunction

   function automatic logic [63:0] dflt(logic [31:0] a);
      return {~a, a ^ 32'h5a5a_5a5a};
   endfunction

   // reference: one buffer tile lands at its place in a channel-major rc x rc image
   task automatic model_buf();
      logic [31:0] rc = 32'(RC_Size) - 32'(RC_Size) % 8;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 8; r++) begin
            logic [31:0] a = (mtc + c) * rc * rc + (mtr + r) * rc + mcol;
            tile[c][r] = {$urandom(), $urandom()};
            wq.push_back('{a, tile[c][r]});
            ref_mem[a] = tile[c][r];
         end
      mcol += 8;
      if (mcol >= rc) begin
         mcol = 0;
         mtr += 8;
         if (mtr >= rc) begin
            mtr = 0;
            mtc += 4;
         end
      end
      exp_fin++;
   endtask

   task automatic model_dram();
      logic [31:0] oc = 32'(OC_Num) - 32'(OC_Num) % 4;
      logic [31:0] rc = 32'(RC_Size) - 32'(RC_Size) % 8;
      for (logic [31:0] k = 0; k < oc * rc * rc / 8; k++) begin
         logic [63:0] v = ref_mem.exists(k * 8) ? ref_mem[k * 8] : dflt(k * 8);
         rq.push_back(k * 8);
         dq.push_back('{output_start_address + k * 8, {32'd0, v[31:0]}});
         dq.push_back('{output_start_address + k * 8 + 4, {32'd0, v[63:32]}});
      end
      mtc = 0;
      mtr = 0;
      mcol = 0;
      exp_fin++;
   endtask

   task automatic pulse(input bit b, input bit d);
      @(negedge clock);
      start_buffer_store = b;
      start_DRAM_store = d;
      @(negedge clock);
      start_buffer_store = 0;
      start_DRAM_store = 0;
   endtask

   task automatic wait_done(input string n);
      for (int i = 0; i < 20000 && fin_cnt < exp_fin; i++) @(negedge clock);
      chk({n, "_finished"}, 64'(fin_cnt), 64'(exp_fin));
      chk({n, "_pending"}, 64'(wq.size() + rq.size() + dq.size()), 0);
      @(negedge clock);
      chk({n, "_idle"}, busy, 0);
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_strobes"}, {OB_r_en, Output_SRAM_w_en, Output_SRAM_r_en, DRAM_Write, busy, finished}, 0);
      chk({n, "_ob_dram_data"}, {OB_r_ch, OB_r_row, DRAM_WriteData}, 0);
      chk({n, "_addrs"}, {Output_SRAM_w_addr, Output_SRAM_r_addr}, 0);
      chk({n, "_dram_addr_wd"}, {DRAM_Address, 32'd0} | Output_SRAM_w_d, 0);
   endtask

   always @(negedge clock) if (reset && finished) fin_cnt++;

   always @(negedge clock) begin
      OB_r_data = ob_prev ? tile[ob_pc][ob_pr] : {$urandom(), $urandom()};
      ob_prev = reset && OB_r_en;
      ob_pc = OB_r_ch;
      ob_pr = OB_r_row;
   end

   always @(negedge clock) begin
      xfer_t e;
      if (!reset) begin
         w_pend = 0;
         Output_SRAM_w_done = 0;
      end else if (Output_SRAM_w_en) begin
         if (!w_pend) begin
            w_pend = 1;
            w_wait = $urandom_range(0, 2);
            w_a = Output_SRAM_w_addr;
            w_dd = Output_SRAM_w_d;
         end else begin
            chk("sram_w_hold_addr", Output_SRAM_w_addr, w_a);
            chk("sram_w_hold_data", Output_SRAM_w_d, w_dd);
         end
         if (w_wait == 0) begin
            Output_SRAM_w_done = 1;
            w_pend = 0;
            sram[w_a] = w_dd;
            w_log.push_back(w_a);
            if (wq.size() == 0) miss("sram_w_unexpected", w_a);
            else begin
               e = wq.pop_front();
               chk("sram_w_addr", w_a, e.a);
               chk("sram_w_data", w_dd, e.d);
            end
         end else begin
            w_wait--;
            Output_SRAM_w_done = 0;
         end
      end else Output_SRAM_w_done = $urandom_range(0, 3) == 0;
   end

   always @(negedge clock) begin
      logic [31:0] ea;
      if (!reset) begin
         r_pend = 0;
         Output_SRAM_d_ready = 0;
      end else if (Output_SRAM_r_en) begin
         if (!r_pend) begin
            r_pend = 1;
            r_wait = $urandom_range(0, 3);
            r_a = Output_SRAM_r_addr;
         end else chk("sram_r_hold_addr", Output_SRAM_r_addr, r_a);
         if (r_wait == 0) begin
            Output_SRAM_d_ready = 1;
            Output_SRAM_r_d = sram.exists(r_a) ? sram[r_a] : dflt(r_a);
            r_pend = 0;
            if (rq.size() == 0) miss("sram_r_unexpected", r_a);
            else begin
               ea = rq.pop_front();
               chk("sram_r_addr", r_a, ea);
            end
         end else begin
            r_wait--;
            Output_SRAM_d_ready = 0;
            Output_SRAM_r_d = {$urandom(), $urandom()};
         end
      end else begin
         Output_SRAM_d_ready = $urandom_range(0, 3) == 0;
         Output_SRAM_r_d = {$urandom(), $urandom()};
      end
   end

   always @(negedge clock) begin
      xfer_t e;
      if (!reset) begin
         d_pend = 0;
         DRAM_WriteDone = 0;
      end else if (DRAM_Write) begin
         if (!d_pend) begin
            d_pend = 1;
            d_wait = dram_delay < 0 ? int'($urandom_range(0, 3)) : dram_delay;
            d_a = DRAM_Address;
            d_dd = DRAM_WriteData;
         end else begin
            chk("dram_hold_addr", DRAM_Address, d_a);
            chk("dram_hold_data", DRAM_WriteData, d_dd);
         end
         if (d_wait == 0) begin
            DRAM_WriteDone = 1;
            d_pend = 0;
            d_log.push_back(d_a);
            if (dq.size() == 0) miss("dram_unexpected", d_a);
            else begin
               e = dq.pop_front();
               chk("dram_addr", d_a, e.a);
               chk("dram_data", d_dd, e.d);
            end
         end else begin
            d_wait--;
            DRAM_WriteDone = 0;
         end
      end else DRAM_WriteDone = $urandom_range(0, 3) == 0;
   end

   initial begin
      reset = 0;
      start_buffer_store = 0;
      start_DRAM_store = 0;
      OC_Num = 4;
      RC_Size = 8;
      output_start_address = 0;
      dram_delay = -1;
      total = 0;
      bad = 0;
      fin_cnt = 0;
      exp_fin = 0;
      mtc = 0;
      mtr = 0;
      mcol = 0;
      OB_r_data = 0;
      Output_SRAM_r_d = 0;
      Output_SRAM_d_ready = 0;
      Output_SRAM_w_done = 0;
      DRAM_WriteDone = 0;
      repeat (3) @(negedge clock);
      chk_zero("reset");
      reset = 1;
      repeat (2) @(negedge clock);
      chk("idle_after_reset", busy, 0);

      w_log.delete();
      model_buf();
      pulse(1, 0);
      wait_done("buf_8x8");
      chk("buf_8x8_writes", 64'(w_log.size()), 32);
      chk("buf_8x8_ch1_r2", w_log[10], 80);

      output_start_address = 32'h1000;
      d_log.delete();
      model_dram();
      pulse(0, 1);
      wait_done("dram_8x8");
      chk("dram_8x8_writes", 64'(d_log.size()), 64);
      chk("dram_8x8_first", d_log[0], 32'h1000);
      chk("dram_8x8_second", d_log[1], 32'h1004);
      chk("dram_8x8_last", d_log[63], 32'h10fc);

      RC_Size = 16;
      for (int i = 0; i < 5; i++) begin
         w_log.delete();
         model_buf();
         pulse(1, 0);
         wait_done("buf_16x16");
         chk("tile_base", w_log[0], bases[i]);
      end

      model_buf();
      pulse(1, 1);
      repeat (5) @(negedge clock);
      pulse(0, 1);
      wait_done("buf_priority");

      RC_Size = 8;
      OC_Num = 5;
      dram_delay = 5;
      model_dram();
      pulse(0, 1);
      wait_done("dram_slow");
      dram_delay = -1;

      OC_Num = 3;
      model_dram();
      pulse(0, 1);
      chk("oc0_finished_early", finished, 0);
      @(negedge clock);
      chk("oc0_finished", finished, 1);
      wait_done("oc0");

      OC_Num = 4;
      output_start_address = 32'h2000;
      model_dram();
      pulse(0, 1);
      for (int i = 0; i < 2000 && !(DRAM_Write && DRAM_Address[2]); i++) @(negedge clock);
      chk("reach_hi_half", DRAM_Write && DRAM_Address[2], 1);
      #2 reset = 0;
      #1 chk("rst_dram_write", DRAM_Write, 0);
      chk_zero("rst_mid");
      rq.delete();
      dq.delete();
      exp_fin--;
      repeat (2) @(negedge clock);
      reset = 1;
      repeat (4) @(negedge clock);
      chk("post_rst_idle", busy, 0);
      model_dram();
      pulse(0, 1);
      wait_done("dram_after_rst");

      for (int it = 0; it < 4; it++) begin
         OC_Num = 7'($urandom_range(4, 9));
         RC_Size = 7'($urandom_range(8, 17));
         output_start_address = 32'($urandom_range(0, 65535)) << 3;
         for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
            model_buf();
            pulse(1, 0);
            wait_done("rand_buf");
         end
         model_dram();
         pulse(0, 1);
         wait_done("rand_dram");
      end

      chk("queues_empty", 64'(wq.size() + rq.size() + dq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
